// File: rtl/uart_rx_if.sv
// Serial input, tick enable and received-byte outputs of the UART receiver.
// The slave modport is the receiver side; the master modport is whatever drives the line.
interface uart_rx_if;
  logic       tick;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  tick,
    input  rx,
    output data_out,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport master (
    output tick,
    output rx,
    input  data_out,
    input  rx_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with an oversampling tick enable, a 2-flop input synchronizer
// and registered one-cycle rx_valid / frame_err pulses.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);
  localparam int unsigned    CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          sync_q, rx_s_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    if (bus.tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            cnt_d   = '0;
            state_d = START;
          end
        end
        START: begin
          // Mid-start-bit recheck rejects glitches shorter than half a bit.
          if (cnt_q == CNT_MID) begin
            cnt_d   = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_END) begin
            shift_d[bit_idx_q] = rx_s_q;
            cnt_d              = '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_d = '0;
              state_d   = STOP;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_END) begin
            cnt_d = '0;
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      sync_q    <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      sync_q    <= bus.rx;
      rx_s_q    <= sync_q;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
